// File: rtl/mac_result_drain.sv
// mac_result_drain: rounds and saturates rows of signed accumulators to the
// output width, buffers them in a 2-entry FIFO and frames them into groups
// of ROWS rows. It flags saturation per frame and pulses frame_done when the
// last row of a frame leaves the block.
//
// state | meaning
// IDLE  | no frame in flight; the first accepted row starts a frame
// RUN   | frame started, still accepting rows
// DRAIN | all ROWS rows accepted, waiting for the last one to leave
module mac_result_drain #(
  parameter int COL   = 16,
  parameter int ACC_W = 32,
  parameter int OUT_W = 16,
  parameter int ROWS  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   acc_valid,
  output logic                   acc_ready,
  input  logic [COL*ACC_W-1:0]   acc_data,
  input  logic [3:0]             frac_shift,
  input  logic                   round_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COL*OUT_W-1:0]   out_data,
  output logic                   out_last,
  output logic                   sat_flag,
  output logic                   frame_done,
  output logic                   busy
);

  localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic signed [ACC_W:0] MAX_V = (ACC_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [ACC_W:0] MIN_V = (ACC_W+1)'(-(2**(OUT_W-1)));

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t               state_q;
  logic [3:0]           shift_q;
  logic                 rnd_q;
  logic                 sat_q;
  logic [CW-1:0]        in_cnt_q;
  logic [CW-1:0]        out_cnt_q, out_cnt_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [COL*OUT_W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic                 fd_q, fd_d;

  logic                 push, pop, last_row;
  logic [3:0]           eff_shift;
  logic                 eff_rnd;
  logic [COL*OUT_W-1:0] row_res;
  logic [COL-1:0]       row_sat;

  assign acc_ready  = (cnt_q != 2'd2) && (state_q != DRAIN);
  assign push       = acc_valid && acc_ready;
  assign out_valid  = (cnt_q != 2'd0);
  assign pop        = out_valid && out_ready;
  assign last_row   = (out_cnt_q == CW'(ROWS - 1));
  assign out_last   = out_valid && last_row;
  assign out_data   = e0_q;
  assign sat_flag   = sat_q;
  assign frame_done = fd_q;
  assign busy       = (state_q != IDLE);

  // The first row of a frame is converted with the live controls, which are
  // latched in that same cycle; later rows use the latched copy.
  assign eff_shift = (state_q == IDLE) ? frac_shift : shift_q;
  assign eff_rnd   = (state_q == IDLE) ? round_en   : rnd_q;

  // One extra bit of headroom keeps the rounding add from wrapping.
  for (genvar k = 0; k < COL; k++) begin : g_elem
    logic signed [ACC_W:0] ext, rnd_add, sum, shr;
    logic                  hi, lo;
    assign ext     = (ACC_W+1)'($signed(acc_data[k*ACC_W +: ACC_W]));
    assign rnd_add = (eff_rnd && (eff_shift != 4'd0)) ?
                     ((ACC_W+1)'(1) << (eff_shift - 4'd1)) : '0;
    assign sum     = ext + rnd_add;
    assign shr     = sum >>> eff_shift;
    assign hi      = (shr > MAX_V);
    assign lo      = (shr < MIN_V);
    assign row_sat[k] = hi || lo;
    assign row_res[k*OUT_W +: OUT_W] = hi ? MAX_V[OUT_W-1:0] :
                                       lo ? MIN_V[OUT_W-1:0] : shr[OUT_W-1:0];
  end

  // Frame sequencing: latch controls at frame start, count accepted rows.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      in_cnt_q <= '0;
      shift_q  <= '0;
      rnd_q    <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (push) begin
            shift_q <= frac_shift;
            rnd_q   <= round_en;
            sat_q   <= |row_sat;
            if (ROWS == 1) begin
              state_q <= DRAIN;
            end else begin
              state_q  <= RUN;
              in_cnt_q <= CW'(1);
            end
          end
        end
        RUN: begin
          if (push) begin
            sat_q <= sat_q || (|row_sat);
            if (in_cnt_q == CW'(ROWS - 1)) begin
              state_q  <= DRAIN;
              in_cnt_q <= '0;
            end else begin
              in_cnt_q <= in_cnt_q + CW'(1);
            end
          end
        end
        DRAIN: begin
          if (pop && last_row) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // FIFO, output row counter and frame_done next-state.
  always_comb begin
    cnt_d     = cnt_q;
    e0_d      = e0_q;
    e1_d      = e1_q;
    out_cnt_d = out_cnt_q;
    fd_d      = pop && last_row;
    if (pop) out_cnt_d = last_row ? '0 : out_cnt_q + CW'(1);
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) e0_d = row_res;
        else               e1_d = row_res;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        cnt_d = cnt_q - 2'd1;
      end
      // Only reachable with one entry: head leaves, new row becomes head.
      2'b11: e0_d = row_res;
      default: ;
    endcase
  end

  // Control registers of the FIFO and output side.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      out_cnt_q <= '0;
      fd_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      out_cnt_q <= out_cnt_d;
      fd_q      <= fd_d;
    end
  end

  // FIFO storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    e0_q <= e0_d;
    e1_q <= e1_d;
  end

endmodule
